// File: rtl/l0_skew_feeder.sv
// l0_skew_feeder: per-row input FIFOs drained with a one-cycle-per-row diagonal skew
// so each wavefront reaches the MAC array west edge aligned with its instruction.
module l0_skew_feeder #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [row*bw-1:0] in,
    input  logic              rd,
    input  logic [1:0]        mode,
    output logic [row*bw-1:0] out,
    output logic [row*2-1:0]  inst,
    output logic              o_ready,
    output logic              o_valid,
    output logic [1:0]        o_err
);
    localparam int AW = $clog2(depth);

    logic [AW:0]   wp_q;
    logic [AW:0]   rp_q  [row];
    logic [bw-1:0] mem_q [row][depth];
    logic [2:0]    dl_q  [row-1];
    logic [row-1:0] rs, full, empty;
    logic [1:0]    m     [row];
    logic          wen;

    // Row 0 sees rd directly; row r sees it through r stages of the {rd, mode} delay line.
    always_comb begin
        rs[0] = rd;
        m[0]  = mode;
        for (int r = 1; r < row; r++) begin
            rs[r] = dl_q[r-1][2];
            m[r]  = dl_q[r-1][1:0];
        end
    end

    always_comb begin
        for (int r = 0; r < row; r++) begin
            empty[r] = wp_q == rp_q[r];
            full[r]  = (wp_q[AW] != rp_q[r][AW]) && (wp_q[AW-1:0] == rp_q[r][AW-1:0]);
        end
    end

    assign o_ready = ~|full;
    assign o_valid = &(~empty);
    assign wen     = wr & o_ready;

    always_ff @(posedge clk) begin
        if (wen)
            for (int r = 0; r < row; r++)
                mem_q[r][wp_q[AW-1:0]] <= in[r*bw +: bw];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q  <= '0;
            out   <= '0;
            inst  <= '0;
            o_err <= '0;
            for (int r = 0; r < row; r++) rp_q[r] <= '0;
            for (int i = 0; i < row - 1; i++) dl_q[i] <= '0;
        end else begin
            if (wen) wp_q <= wp_q + (AW+1)'(1);
            dl_q[0] <= {rd, mode};
            for (int i = 1; i < row - 1; i++) dl_q[i] <= dl_q[i-1];
            for (int r = 0; r < row; r++) begin
                inst[r*2 +: 2] <= (rs[r] && !empty[r]) ? m[r] : 2'b00;
                if (rs[r] && !empty[r]) begin
                    out[r*bw +: bw] <= mem_q[r][rp_q[r][AW-1:0]];
                    rp_q[r]         <= rp_q[r] + (AW+1)'(1);
                end
            end
            o_err <= o_err | {wr & ~o_ready, |(rs & empty)};
        end
    end
endmodule

// File: tb/tb_l0_skew_feeder.sv
// tb_l0_skew_feeder: queue-based reference model feeds a per-row scoreboard;
// a monitor pops an entry whenever a row presents a non-zero instruction.
module tb_l0_skew_feeder;
    localparam int ROW = 8, BW = 4, DEPTH = 64;

    logic                clk = 0, reset = 0, wr = 0, rd = 0;
    logic [1:0]          mode = 0;
    logic [ROW*BW-1:0]   in_v = '0;
    logic [ROW*BW-1:0]   out_v;
    logic [ROW*2-1:0]    inst_v;
    logic                o_ready, o_valid;
    logic [1:0]          o_err;

    always #5 clk = ~clk;

    l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .in(in_v), .rd(rd), .mode(mode),
        .out(out_v), .inst(inst_v), .o_ready(o_ready), .o_valid(o_valid), .o_err(o_err)
    );

    typedef struct packed {
        logic [BW-1:0] d;
        logic [1:0]    m;
        int            stamp;
    } exp_t;

    int            total = 0, bad = 0, cyc = 0;
    bit            in_rst = 1;
    logic [BW-1:0] dq [ROW][$];
    exp_t          sb [ROW][$];
    logic [BW-1:0] exp_out [ROW];
    logic [1:0]    exp_err = 0;
    bit   [2:0]    rdlog [0:65535];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, req);
        end
    endtask

    function automatic bit m_ready();
        for (int r = 0; r < ROW; r++) if (dq[r].size() >= DEPTH) return 0;
        return 1;
    endfunction

    function automatic bit m_valid();
        for (int r = 0; r < ROW; r++) if (dq[r].size() == 0) return 0;
        return 1;
    endfunction

    // One clock edge of the reference: reads see pre-edge contents, then the write lands.
    task automatic model(bit w, logic [ROW*BW-1:0] d, bit r, logic [1:0] md);
        bit rdy;
        rdy = m_ready();
        rdlog[cyc] = {r, md};
        for (int k = 0; k < ROW; k++) begin
            if (cyc >= k && rdlog[cyc-k][2]) begin
                if (dq[k].size() > 0) begin
                    exp_out[k] = dq[k].pop_front();
                    sb[k].push_back('{exp_out[k], rdlog[cyc-k][1:0], cyc + 1});
                end else exp_err[0] = 1;
            end
        end
        if (w) begin
            if (rdy) for (int k = 0; k < ROW; k++) dq[k].push_back(d[k*BW +: BW]);
            else exp_err[1] = 1;
        end
    endtask

    task automatic step(bit w, logic [ROW*BW-1:0] d, bit r, logic [1:0] md);
        @(negedge clk);
        wr = w; in_v = d; rd = r; mode = md;
        if (in_rst) rdlog[cyc] = 0;
        else model(w, d, r, md);
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(int n);
        repeat (n) step(0, '0, 0, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 0;
        in_rst = 1;
        for (int k = 0; k < ROW; k++) begin
            dq[k].delete();
            sb[k].delete();
            exp_out[k] = '0;
        end
        exp_err = 0;
        for (int k = 1; k <= ROW; k++) if (cyc - k >= 0) rdlog[cyc-k] = 0;
        #1;
        chk("rst out", out_v, 0);
        chk("rst inst", inst_v, 0);
        chk("rst o_valid", o_valid, 0);
        chk("rst o_ready", o_ready, 1);
        chk("rst o_err", o_err, 0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        reset = 1; in_rst = 0;
        wr = 0; rd = 0; mode = 0; in_v = '0;
        model(0, '0, 0, 2'b00);
        @(posedge clk);
        cyc++;
    endtask

    function automatic logic [1:0] rmode();
        return $urandom_range(0, 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [ROW*BW-1:0] rvec();
        logic [ROW*BW-1:0] v;
        for (int k = 0; k < ROW; k++) v[k*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        for (int r = 0; r < ROW; r++) begin
            logic [1:0] ii;
            exp_t e;
            ii = inst_v[r*2 +: 2];
            chk($sformatf("out[%0d]", r), out_v[r*BW +: BW], exp_out[r]);
            if (ii != 2'b00) begin
                if (sb[r].size() == 0) chk($sformatf("stray inst[%0d]", r), ii, 0);
                else begin
                    e = sb[r].pop_front();
                    chk($sformatf("inst[%0d]", r), ii, e.m);
                    chk($sformatf("data[%0d]", r), out_v[r*BW +: BW], e.d);
                    chk($sformatf("latency[%0d]", r), cyc, e.stamp);
                end
            end else if (sb[r].size() > 0 && sb[r][0].stamp <= cyc) begin
                e = sb[r].pop_front();
                chk($sformatf("missed inst[%0d]", r), ii, e.m);
            end
        end
        chk("o_ready", o_ready, m_ready());
        chk("o_valid", o_valid, m_valid());
        chk("o_err", o_err, exp_err);
    end

    initial begin
        for (int k = 0; k < ROW; k++) exp_out[k] = '0;
        repeat (2) @(negedge clk);
        release_rst();

        // three known vectors read back-to-back as execute
        step(1, {ROW{4'h3}}, 0, 2'b00);
        step(1, {ROW{4'h5}}, 0, 2'b00);
        step(1, {ROW{4'h7}}, 0, 2'b00);
        repeat (3) step(0, '0, 1, 2'b10);
        idle(10);

        // fill, overflow attempt, drain with pointer wrap
        repeat (DEPTH) step(1, rvec(), 0, 2'b00);
        step(1, rvec(), 0, 2'b00);
        repeat (DEPTH) step(0, '0, 1, rmode());
        idle(10);

        // read on empty rows
        step(0, '0, 1, 2'b10);
        idle(10);

        // mode sequence 01 then 10
        step(1, rvec(), 0, 2'b00);
        step(1, rvec(), 0, 2'b00);
        step(0, '0, 1, 2'b01);
        step(0, '0, 1, 2'b10);
        idle(10);

        // full buffer with simultaneous write and read
        repeat (DEPTH) step(1, rvec(), 0, 2'b00);
        step(1, rvec(), 1, 2'b10);
        idle(10);
        repeat (DEPTH - 1) step(0, '0, 1, rmode());
        idle(10);

        // random traffic
        repeat (600) step($urandom_range(0, 1), rvec(), $urandom_range(0, 9) < 4, rmode());
        idle(10);

        // reset while a wavefront is still in flight to the lower rows
        do_reset();
        step(0, '0, 1, 2'b10);
        release_rst();
        repeat (3) step(1, rvec(), 0, 2'b00);
        step(0, '0, 1, 2'b10);
        idle(3);
        do_reset();
        repeat (2) step(1, rvec(), 1, 2'b10);
        release_rst();
        idle(12);

        for (int r = 0; r < ROW; r++) chk($sformatf("drained[%0d]", r), sb[r].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
